// File: rtl/fetch_unit.sv
// Instruction fetch stage: samples the PC, reads instruction memory over a
// req/ack handshake and hands the word to decode over valid/ready. Pulses
// the counter enable once per fetched word and discards in-flight work on
// a redirect (flush).
module fetch_unit #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] pc,
    output logic                     pc_enable,
    input  logic                     flush,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [DATA_WIDTH-1:0]    instr_data,
    output logic [ADDRESS_WIDTH-1:0] instr_pc
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                   state, state_nx;
    logic                     mem_req_nx, instr_valid_nx, pc_enable_nx;
    logic [ADDRESS_WIDTH-1:0] mem_addr_nx, instr_pc_nx;
    logic [DATA_WIDTH-1:0]    instr_data_nx;

    // State and registered outputs; reset wins over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= LOAD;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instr_valid <= 1'b0;
            instr_data  <= '0;
            instr_pc    <= '0;
            pc_enable   <= 1'b0;
        end else begin
            state       <= state_nx;
            mem_req     <= mem_req_nx;
            mem_addr    <= mem_addr_nx;
            instr_valid <= instr_valid_nx;
            instr_data  <= instr_data_nx;
            instr_pc    <= instr_pc_nx;
            pc_enable   <= pc_enable_nx;
        end
    end

    // Next-state and next-output logic. pc_enable defaults low so it can
    // only ever be a single-cycle pulse on the FETCH->HOLD transition.
    always_comb begin
        state_nx       = state;
        mem_req_nx     = mem_req;
        mem_addr_nx    = mem_addr;
        instr_valid_nx = instr_valid;
        instr_data_nx  = instr_data;
        instr_pc_nx    = instr_pc;
        pc_enable_nx   = 1'b0;

        case (state)
            LOAD: begin
                if (flush) begin
                    // Counter is being reloaded this cycle; sample it next cycle.
                    instr_valid_nx = 1'b0;
                    mem_req_nx     = 1'b0;
                end else begin
                    mem_addr_nx = pc;
                    mem_req_nx  = 1'b1;
                    state_nx    = FETCH;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    mem_req_nx = 1'b0;
                    if (flush) begin
                        // Word arrived for a path that was just abandoned.
                        instr_valid_nx = 1'b0;
                        state_nx       = LOAD;
                    end else begin
                        instr_data_nx  = mem_rdata;
                        instr_pc_nx    = mem_addr;
                        instr_valid_nx = 1'b1;
                        pc_enable_nx   = 1'b1;
                        state_nx       = HOLD;
                    end
                end else if (flush) begin
                    // Request is outstanding; let memory finish it, then drop it.
                    state_nx = DRAIN;
                end
            end
            HOLD: begin
                if (flush || (instr_valid && instr_ready)) begin
                    instr_valid_nx = 1'b0;
                    state_nx       = LOAD;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    mem_req_nx     = 1'b0;
                    instr_valid_nx = 1'b0;
                    state_nx       = LOAD;
                end
            end
            default: state_nx = LOAD;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run scored against a transaction-level model (delivered PC sequence and
// memory contents) with an upstream counter and a variable-latency memory.
module tb_fetch_unit;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset, flush, mem_ack, instr_ready;
    logic [AW-1:0] pc, flush_tgt;
    logic [DW-1:0] mem_rdata;
    logic          pc_enable, mem_req, instr_valid;
    logic [AW-1:0] mem_addr, instr_pc;
    logic [DW-1:0] instr_data;

    int            nchk = 0, nerr = 0;
    int            ndel, npcen, cyc, lat, wcnt;
    bit            rnd_lat;
    logic [AW-1:0] exp_pc;

    fetch_unit #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .pc         (pc),
        .pc_enable  (pc_enable),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_data (instr_data),
        .instr_pc   (instr_pc)
    );

    always #5 clock = ~clock;

    // Memory contents: a fixed function of the address (0x0010 -> 0xA5A5).
    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return a ^ 16'hA5B5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: score the handshake, advance the counter model, check
    // protocol invariants, then drive memory for the next cycle.
    task automatic step();
        logic          fl, en, rst, v_hold, rq_hold;
        logic [AW-1:0] tgt, a_prev, ip_prev;
        logic [DW-1:0] d_prev;
        fl      = flush;
        en      = pc_enable;
        rst     = reset;
        tgt     = flush_tgt;
        v_hold  = !rst && !fl && instr_valid && !instr_ready;
        rq_hold = !rst && mem_req && !mem_ack;
        a_prev  = mem_addr;
        ip_prev = instr_pc;
        d_prev  = instr_data;
        if (!rst && !fl && instr_valid && instr_ready) begin
            chk("dlv_pc", 32'(instr_pc), 32'(exp_pc));
            chk("dlv_data", 32'(instr_data), 32'(memf(exp_pc)));
            exp_pc = exp_pc + 16'd1;
            ndel++;
        end
        if (!rst && fl) exp_pc = tgt;
        @(posedge clock);
        #1;
        cyc++;
        if (fl) pc = tgt;
        else if (en) pc = pc + 16'd1;
        npcen += int'(pc_enable);
        if (en) chk("pcen_pulse", 32'(pc_enable), 32'd0);
        if (v_hold) begin
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_data", 32'(instr_data), 32'(d_prev));
            chk("hold_pc", 32'(instr_pc), 32'(ip_prev));
        end
        if (rq_hold) begin
            chk("req_held", 32'(mem_req), 32'd1);
            chk("addr_held", 32'(mem_addr), 32'(a_prev));
        end
        if (mem_req) begin
            if (wcnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = memf(mem_addr);
                wcnt      = 0;
                if (rnd_lat) lat = $urandom_range(0, 3);
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
                wcnt++;
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 16'($urandom);
            wcnt      = 0;
        end
    endtask

    task automatic reset_seq(input logic [AW-1:0] pc0);
        reset = 1'b1;
        flush = 1'b0;
        step();
        step();
        pc     = pc0;
        reset  = 1'b0;
        exp_pc = pc0;
        npcen  = 0;
    endtask

    task automatic wait_valid(input string tag, input int n);
        int k = 0;
        while (!instr_valid && k < n) begin
            step();
            k++;
        end
        chk({tag, "_valid_to"}, 32'(instr_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   found, t_prev, nbad;
        logic prev_req;
        reset = 1'b1; flush = 1'b0; flush_tgt = '0; mem_ack = 1'b0;
        mem_rdata = '0; instr_ready = 1'b1; pc = 16'h0010;
        lat = 2; wcnt = 0; rnd_lat = 1'b0; ndel = 0; npcen = 0; cyc = 0;
        exp_pc = 16'h0010;

        // Test 1: basic fetch, ack two cycles after req, ready high.
        step();
        step();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_data", 32'(instr_data), 32'd0);
        chk("rst_ipc", 32'(instr_pc), 32'd0);
        chk("rst_pcen", 32'(pc_enable), 32'd0);
        reset = 1'b0; exp_pc = pc; npcen = 0;
        step();
        chk("t1_req", 32'(mem_req), 32'd1);
        chk("t1_addr", 32'(mem_addr), 32'h0010);
        wait_valid("t1", 10);
        chk("t1_data", 32'(instr_data), 32'hA5A5);
        chk("t1_ipc", 32'(instr_pc), 32'h0010);
        chk("t1_pcen_on", 32'(pc_enable), 32'd1);
        repeat (4) step();
        chk("t1_pcen_cnt", 32'(npcen), 32'd1);
        chk("t1_next_addr", 32'(mem_addr), 32'h0011);

        // Test 2: decode stalls for 5 cycles.
        lat = 2; instr_ready = 1'b0;
        reset_seq(16'h0010);
        step();
        wait_valid("t2", 10);
        repeat (5) begin
            step();
            chk("t2_valid", 32'(instr_valid), 32'd1);
            chk("t2_data", 32'(instr_data), 32'hA5A5);
            chk("t2_ipc", 32'(instr_pc), 32'h0010);
            chk("t2_req", 32'(mem_req), 32'd0);
        end
        chk("t2_pcen_cnt", 32'(npcen), 32'd1);
        instr_ready = 1'b1;
        step();
        chk("t2_release", 32'(instr_valid), 32'd0);

        // Test 3: zero-latency memory, 3 cycles per instruction.
        lat = 0; instr_ready = 1'b1;
        reset_seq(16'h0010);
        found = 0; t_prev = 0; prev_req = 1'b0;
        for (int k = 0; k < 40 && found < 3; k++) begin
            step();
            if (mem_req && !prev_req) begin
                chk("t3_addr", 32'(mem_addr), 32'h0010 + 32'(found));
                if (found > 0) chk("t3_gap", 32'(cyc - t_prev), 32'd3);
                t_prev = cyc;
                found++;
            end
            prev_req = mem_req;
        end
        chk("t3_found", 32'(found), 32'd3);

        // Test 4: flush while request outstanding -> drain, refetch at target.
        lat = 3;
        reset_seq(16'h0010);
        step();
        chk("t4_req", 32'(mem_req), 32'd1);
        flush = 1'b1; flush_tgt = 16'h0040;
        step();
        flush = 1'b0;
        chk("t4_drain_req", 32'(mem_req), 32'd1);
        nbad = 0; found = 0; prev_req = 1'b1;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step();
            if (instr_valid || pc_enable) nbad++;
            if (mem_req && !prev_req) begin
                chk("t4_new_addr", 32'(mem_addr), 32'h0040);
                found = 1;
            end
            prev_req = mem_req;
        end
        chk("t4_found", 32'(found), 32'd1);
        chk("t4_no_stale", 32'(nbad), 32'd0);
        wait_valid("t4", 10);
        chk("t4_ipc", 32'(instr_pc), 32'h0040);
        step();

        // Test 5: flush in the same cycle as mem_ack.
        lat = 1;
        reset_seq(16'h0010);
        step();
        for (int k = 0; k < 10 && !mem_ack; k++) step();
        chk("t5_ack", 32'(mem_ack), 32'd1);
        flush = 1'b1; flush_tgt = 16'h0080;
        step();
        flush = 1'b0;
        chk("t5_valid", 32'(instr_valid), 32'd0);
        chk("t5_pcen", 32'(pc_enable), 32'd0);
        chk("t5_req", 32'(mem_req), 32'd0);
        step();
        chk("t5_req2", 32'(mem_req), 32'd1);
        chk("t5_addr", 32'(mem_addr), 32'h0080);
        chk("t5_valid2", 32'(instr_valid), 32'd0);
        chk("t5_pcen_cnt", 32'(npcen), 32'd0);

        // Test 6: reset during HOLD (first HOLD cycle still advances the counter).
        lat = 0; instr_ready = 1'b0;
        reset_seq(16'h0010);
        wait_valid("t6", 10);
        reset = 1'b1;
        step();
        chk("t6_req", 32'(mem_req), 32'd0);
        chk("t6_addr", 32'(mem_addr), 32'd0);
        chk("t6_valid", 32'(instr_valid), 32'd0);
        chk("t6_data", 32'(instr_data), 32'd0);
        chk("t6_ipc", 32'(instr_pc), 32'd0);
        chk("t6_pcen", 32'(pc_enable), 32'd0);
        reset = 1'b0; exp_pc = pc;
        step();
        chk("t6_restart_req", 32'(mem_req), 32'd1);
        chk("t6_restart_addr", 32'(mem_addr), 32'h0011);
        instr_ready = 1'b1;
        wait_valid("t6b", 10);
        step();

        // Randomized run: random latency, backpressure and redirects,
        // starting near the top of the address space to exercise wrap.
        rnd_lat = 1'b1; lat = 1;
        reset_seq(16'hFFFE);
        ndel = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) < 6) begin
                flush       = 1'b1;
                flush_tgt   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                instr_ready = 1'b0;
            end else begin
                flush       = 1'b0;
                instr_ready = ($urandom_range(0, 9) < 7);
            end
            step();
        end
        flush = 1'b0;
        chk("rnd_progress", 32'(ndel > 50), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
